// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin sharing of one start/done MAC among NREQ requesters, with done timeout
module mac_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_acc,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mac_clr,
  output logic                 mac_start,
  output logic [15:0]          mac_a,
  output logic [15:0]          mac_b,
  input  logic                 mac_done,
  input  logic [31:0]          mac_acc
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, idx, idx_n, sel;
  logic [IW:0] s;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] a_n, b_n;
  logic [31:0] acc_n;
  logic err_n;
  // first requester at or after ptr, wrapping; lowest rotated offset wins
  always_comb begin
    sel = ptr;
    s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NREQ)) s = s - (IW+1)'(NREQ);
      if (req[s[IW-1:0]]) sel = s[IW-1:0];
    end
  end
  // next state plus the data that the registered outputs will carry
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    idx_n = idx;
    cnt_n = cnt;
    a_n = mac_a;
    b_n = mac_b;
    acc_n = rsp_acc;
    err_n = rsp_err;
    case (state)
      IDLE: if (|req) begin
        state_n = CLR;
        idx_n = sel;
        a_n = req_a[{sel, 4'b0000} +: 16];
        b_n = req_b[{sel, 4'b0000} +: 16];
      end
      CLR: state_n = START;
      START: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (mac_done) begin
        state_n = RESP;
        acc_n = mac_acc;
        err_n = 1'b0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = RESP;
        acc_n = '0;
        err_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      RESP: begin
        state_n = IDLE;
        ptr_n = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and Moore outputs registered from the upcoming state so every pulse lines up with its state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      cnt <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_acc <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      mac_clr <= 1'b0;
      mac_start <= 1'b0;
      mac_a <= '0;
      mac_b <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      idx <= idx_n;
      cnt <= cnt_n;
      mac_a <= a_n;
      mac_b <= b_n;
      rsp_acc <= acc_n;
      rsp_err <= err_n;
      gnt <= (state_n == CLR) ? NREQ'(1) << idx_n : '0;
      rsp_valid <= (state_n == RESP) ? NREQ'(1) << idx_n : '0;
      busy <= state_n != IDLE;
      mac_clr <= state_n == CLR;
      mac_start <= state_n == START;
    end
  end
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler: directed table, corner sequences and random traffic against a job-level model
module tb_mac_rr_scheduler;
  localparam int N = 4;
  localparam int T = 20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [16*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [31:0] rsp_acc;
  logic rsp_err, busy, mac_clr, mac_start;
  logic [15:0] mac_a, mac_b;
  logic mac_done = 1'b0;
  logic [31:0] mac_acc = '0;
  mac_rr_scheduler #(.NREQ(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_acc(rsp_acc), .rsp_err(rsp_err),
    .busy(busy), .mac_clr(mac_clr), .mac_start(mac_start), .mac_a(mac_a),
    .mac_b(mac_b), .mac_done(mac_done), .mac_acc(mac_acc)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  // MAC stand-in: exact product, done mac_lat cycles into WAIT, optional stray done during START
  int mac_lat = 1, job_lat = 0;
  bit early = 0;
  logic [15:0] ra, rb;
  initial forever begin
    @(posedge clk); #1;
    mac_done = 1'b0;
    if (mac_start) begin
      job_lat = mac_lat;
      ra = mac_a;
      rb = mac_b;
      if (early) begin mac_done = 1'b1; mac_acc = 32'hDEAD_BEEF; end
      if (job_lat < T) begin
        repeat (job_lat + 1) begin @(posedge clk); #1; mac_done = 1'b0; end
        mac_done = 1'b1;
        mac_acc = 32'(ra) * 32'(rb);
      end
    end
  end
  // what the DUT saw at each rising edge
  logic [N-1:0] req_q = '0;
  logic [16*N-1:0] a_q = '0, b_q = '0;
  logic rst_q = 1'b0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    req_q <= req;
    a_q <= req_a;
    b_q <= req_b;
    rst_q <= rst;
  end
  // job-level reference: rr pick at sampling edges, one job at a time, result timing from latency
  bit pending = 0;
  int p_lane = 0, gnt_cyc = 0, last_rsp = -10, ptr_m = 0, m_lane = 0, m_w = 0;
  logic [31:0] p_a = '0, p_b = '0;
  logic [N-1:0] exp_g;
  int gnt_log[$], wait_log[$];
  logic [31:0] acc_log[$];
  bit err_log[$];
  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      pending = 0;
      ptr_m = 0;
    end else begin
      if (pending) begin
        if (rsp_valid != 0 || cyc >= gnt_cyc + 3 + T) begin
          m_w = 3 + (job_lat < T ? job_lat : T - 1);
          chk("rsp_valid", rsp_valid, 32'(1) << p_lane);
          chk("rsp_latency", cyc - gnt_cyc, m_w);
          chk("rsp_acc", rsp_acc, job_lat < T ? p_a * p_b : 32'h0);
          chk("rsp_err", rsp_err, job_lat >= T);
          acc_log.push_back(rsp_acc);
          err_log.push_back(rsp_err);
          wait_log.push_back(cyc - gnt_cyc);
          ptr_m = (p_lane + 1) % N;
          pending = 0;
          last_rsp = cyc;
        end
      end else chk("rsp_valid_quiet", rsp_valid, 0);
      exp_g = '0;
      m_lane = 0;
      if (!pending && rst_q && cyc > last_rsp + 1 && req_q != 0) begin
        m_lane = pick(req_q, ptr_m);
        exp_g = N'(1) << m_lane;
      end
      chk("gnt", gnt, exp_g);
      chk("mac_clr", mac_clr, exp_g != 0);
      if (exp_g != 0) begin
        chk("mac_a", mac_a, a_q[16*m_lane +: 16]);
        chk("mac_b", mac_b, b_q[16*m_lane +: 16]);
        pending = 1;
        p_lane = m_lane;
        p_a = 32'(a_q[16*m_lane +: 16]);
        p_b = 32'(b_q[16*m_lane +: 16]);
        gnt_cyc = cyc;
        gnt_log.push_back(m_lane);
      end
      chk("mac_start", mac_start, pending && cyc == gnt_cyc + 1);
      chk("busy", busy, pending || rsp_valid != 0);
    end
  end
  // requesters drop their line as soon as they see their grant
  task automatic tick();
    @(negedge clk);
    req = req & ~gnt;
  endtask
  task automatic raise(int l, logic [15:0] a, logic [15:0] b);
    req_a[16*l +: 16] = a;
    req_b[16*l +: 16] = b;
    req[l] = 1'b1;
  endtask
  task automatic clear_logs();
    gnt_log.delete();
    acc_log.delete();
    err_log.delete();
    wait_log.delete();
  endtask
  task automatic wait_gnts(int n);
    for (int i = 0; i < 300 && gnt_log.size() < n; i++) tick();
    chk("gnt_count", gnt_log.size(), n);
  endtask
  task automatic wait_rsps(int n);
    for (int i = 0; i < 300 && acc_log.size() < n; i++) tick();
    chk("rsp_count", acc_log.size(), n);
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_acc"}, rsp_acc, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mac_clr"}, mac_clr, 0);
    chk({tag, "_mac_start"}, mac_start, 0);
    chk({tag, "_mac_a"}, mac_a, 0);
    chk({tag, "_mac_b"}, mac_b, 0);
  endtask
  function automatic int gl(int i);
    return gnt_log.size() > i ? gnt_log[i] : -1;
  endfunction
  function automatic logic [31:0] al(int i);
    return acc_log.size() > i ? acc_log[i] : 32'hFFFF_FFFF;
  endfunction
  typedef struct {
    int lane;
    logic [15:0] a, b;
    int lat;
    bit early;
    logic [31:0] acc;
    bit err;
    int lat_cyc;
  } vec_t;
  vec_t tv[7];
  // single-job vectors: expected result and gnt-to-rsp distance
  initial begin
    tv[0] = '{0, 16'd7, 16'd9, 2, 1'b0, 32'd63, 1'b0, 5};
    tv[1] = '{1, 16'hFFFF, 16'hFFFF, 0, 1'b0, 32'hFFFE_0001, 1'b0, 3};
    tv[2] = '{2, 16'd0, 16'd1234, 5, 1'b0, 32'd0, 1'b0, 8};
    tv[3] = '{3, 16'd100, 16'd300, T - 1, 1'b0, 32'd30000, 1'b0, 22};
    tv[4] = '{1, 16'd5, 16'd5, T, 1'b0, 32'd0, 1'b1, 22};
    tv[5] = '{0, 16'd3, 16'd11, 3, 1'b1, 32'd33, 1'b0, 6};
    tv[6] = '{2, 16'h8000, 16'd2, 1, 1'b0, 32'h0001_0000, 1'b0, 4};
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      mac_lat = tv[i].lat;
      early = tv[i].early;
      clear_logs();
      raise(tv[i].lane, tv[i].a, tv[i].b);
      wait_rsps(1);
      chk("tv_lane", gl(0), tv[i].lane);
      chk("tv_acc", al(0), tv[i].acc);
      chk("tv_err", err_log.size() > 0 ? err_log[0] : 1'bx, tv[i].err);
      chk("tv_wait", wait_log.size() > 0 ? wait_log[0] : -1, tv[i].lat_cyc);
      repeat (2) tick();
    end
    early = 0;
    mac_lat = 1;
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'd2;
    end
    req = '1;
    tick();
    rst = 1'b1;
    wait_rsps(4);
    for (int i = 0; i < N; i++) begin
      chk("contention_order", gl(i), i);
      chk("contention_acc", al(i), 32'(2 * (i + 1)));
    end
    clear_logs();
    raise(2, 16'd3, 16'd4);
    wait_rsps(1);
    raise(1, 16'd10, 16'd10);
    raise(3, 16'd20, 16'd20);
    wait_rsps(3);
    chk("rr_first", gl(1), 3);
    chk("rr_second", gl(2), 1);
    tick();
    clear_logs();
    raise(2, 16'd1, 16'd1);
    wait_rsps(1);
    mac_lat = T;
    raise(0, 16'd5, 16'd6);
    wait_gnts(2);
    repeat (4) tick();
    #1 rst = 1'b0;
    #1 chk_zero("midwait");
    repeat (3) tick();
    chk("midwait_no_rsp", acc_log.size(), 1);
    rst = 1'b1;
    clear_logs();
    mac_lat = 1;
    raise(2, 16'd7, 16'd7);
    raise(3, 16'd8, 16'd8);
    wait_rsps(2);
    chk("post_reset_first", gl(0), 2);
    chk("post_reset_second", gl(1), 3);
    tick();
    clear_logs();
    mac_lat = 2;
    raise(0, 16'd2, 16'd3);
    wait_gnts(1);
    tick();
    raise(0, 16'd4, 16'd5);
    raise(1, 16'd6, 16'd7);
    wait_rsps(3);
    chk("b2b_0", gl(0), 0);
    chk("b2b_1", gl(1), 1);
    chk("b2b_2", gl(2), 0);
    chk("b2b_acc", al(1), 32'd42);
    for (int i = 0; i < 600; i++) begin
      tick();
      mac_lat = $urandom_range(0, T + 2);
      early = 1'($urandom_range(0, 1));
      for (int l = 0; l < N; l++)
        if (!req[l] && $urandom_range(0, 5) == 0) raise(l, 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 500 && (req != 0 || pending); i++) tick();
    chk("drain", 32'(req != 0 || pending), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  // hard stop if something stalls every bounded wait
  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_rr_scheduler.md
Name: mac_rr_scheduler

Overview:
- Round-robin scheduler that shares one 16x16 approximate MAC (start/done handshake, 32-bit acc) among NREQ requesters.
- Per job, in order: arbitrates, clears the MAC, launches one multiply, waits for done with a timeout, then returns the result to the granted requester.
- Sits between the DSP lanes and the shared mac_16bit_loa instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1000, max cycles waited for mac_done before aborting a job.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester job request, level, held until gnt
- req_a  in  16*NREQ  operand a, slice i = [16i+15:16i]
- req_b  in  16*NREQ  operand b, same slicing
- gnt  out  NREQ  one-hot, 1-cycle pulse: job accepted, operands latched
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: result for requester i
- rsp_acc  out  32  result, valid while any rsp_valid bit is high
- rsp_err  out  1  qualifies rsp_valid: job timed out
- busy  out  1  high in every state except IDLE
- mac_clr  out  1  active-high clear to MAC accumulator
- mac_start  out  1  start pulse to MAC
- mac_a  out  16  latched operand a
- mac_b  out  16  latched operand b
- mac_done  in  1  MAC completion
- mac_acc  in  32  MAC result

Behaviour:
- Reset (rst low, async): state IDLE, rr pointer=0, wait counter=0.
- Reset outputs: gnt, rsp_valid, rsp_acc, rsp_err, busy, mac_clr, mac_start, mac_a, mac_b all 0.
- Reset mid-job: abandon the job silently, no rsp_valid issued.
- All outputs are registered; Moore FSM with states IDLE, CLR, START, WAIT, RESP.
- IDLE:
  - req sampled only in this state.
  - If req!=0, select the first set bit searching from ptr upward (mod NREQ).
  - Latch idx, mac_a=req_a[idx], mac_b=req_b[idx]; go to CLR.
  - If req==0, stay in IDLE.
- CLR: gnt[idx]=1 and mac_clr=1 for exactly this cycle -> START.
- START: mac_start=1 for exactly this cycle; mac_a/mac_b stable -> WAIT; counter=0.
- WAIT:
  - mac_done sampled only here; done in CLR/START is ignored.
  - mac_done=1 -> capture mac_acc into rsp_acc, rsp_err=0 -> RESP.
  - Else counter+1; when counter reaches TIMEOUT-1 with no done -> rsp_acc=0, rsp_err=1 -> RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: rsp_valid[idx]=1 for one cycle; ptr=(idx+1) mod NREQ -> IDLE.
- Outside RESP: rsp_valid=0; rsp_acc/rsp_err hold their last value.
- mac_a/mac_b hold from latch until the next latch.
- Throughput: a new arbitration is possible the cycle after RESP.
- Minimum job with done on first WAIT cycle: req seen at edge 0 -> gnt during cycle 1 -> start during cycle 2 -> rsp_valid during cycle 4.
- Requester contract: deassert req in the cycle after gnt, or it re-requests and is re-arbitrated behind the others.
- Only one job is ever outstanding; a request arriving while busy waits.
- Fairness: each continuously requesting lane is served once per NREQ jobs.

Test Plan:
- Single job: req[0] with a=7, b=9, MAC done after 3 cycles -> gnt[0] pulse, mac_clr then mac_start single pulses, rsp_valid[0] with rsp_acc=63, rsp_err=0.
- Contention, all four requesters hold req from reset with operands a=i+1, b=2:
  - Grants in order 0, 1, 2, 3.
  - Results in order 2, 4, 6, 8.
- Round-robin pointer: after serving lane 2, raise req[1] and req[3] together -> lane 3 is granted first, then lane 1.
- Timeout: with TIMEOUT=20 and mac_done held low, one req[1] -> rsp_valid[1] exactly 20 WAIT cycles after start, rsp_err=1, rsp_acc=0, then IDLE.
- Reset mid-WAIT: assert rst low during WAIT -> all outputs 0 immediately, no rsp_valid; next req[2] is served normally with ptr=0 search.
- Edge: mac_done in the START cycle is ignored, a later done completes the job. Back-to-back req[0] with req[1] pending -> lane 1 is served before lane 0's second job.
